// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter of I/D-cache line requests onto one pipelined memory,
// with an in-order read-ID FIFO for response routing. Define MEM_ARB_PERF_EN for perf counters.
module mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int LINE_BYTES      = 16,
    parameter int MAX_OUTSTANDING = 10
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    ic_req,
    input  logic                    ic_we,
    input  logic [ADDR_WIDTH-1:0]   ic_addr,
    input  logic [LINE_BYTES*8-1:0] ic_wdata,
    output logic                    ic_gnt,
    output logic                    ic_rvalid,
    output logic [LINE_BYTES*8-1:0] ic_rdata,
    input  logic                    dc_req,
    input  logic                    dc_we,
    input  logic [ADDR_WIDTH-1:0]   dc_addr,
    input  logic [LINE_BYTES*8-1:0] dc_wdata,
    output logic                    dc_gnt,
    output logic                    dc_rvalid,
    output logic [LINE_BYTES*8-1:0] dc_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [LINE_BYTES*8-1:0] mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [LINE_BYTES*8-1:0] mem_rdata,
    output logic                    arb_err
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]             perf_ic_grants,
    output logic [31:0]             perf_dc_grants,
    output logic [31:0]             perf_stall_cycles
`endif
);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {SRC_IC = 1'b0, SRC_DC = 1'b1} src_e;

    src_e          last_q, last_d;
    logic          id_q [MAX_OUTSTANDING];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          can_rd, ic_elig, dc_elig, sel_ic, sel_dc, acc, push, pop, head;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(MAX_OUTSTANDING - 1) ? '0 : p + PW'(1);
    endfunction

    // Full check uses the registered count only, so a same-cycle pop never frees a slot early.
    always_comb begin
        can_rd    = cnt_q < CW'(MAX_OUTSTANDING);
        ic_elig   = ic_req & (ic_we | can_rd);
        dc_elig   = dc_req & (dc_we | can_rd);
        sel_dc    = dc_elig & (!ic_elig | last_q == SRC_IC);
        sel_ic    = ic_elig & !sel_dc;
        mem_req   = sel_ic | sel_dc;
        mem_we    = sel_dc ? dc_we : sel_ic & ic_we;
        mem_addr  = sel_dc ? dc_addr : sel_ic ? ic_addr : '0;
        mem_wdata = sel_dc ? dc_wdata : sel_ic ? ic_wdata : '0;
        ic_gnt    = sel_ic & mem_gnt;
        dc_gnt    = sel_dc & mem_gnt;
        acc       = mem_req & mem_gnt;
        push      = acc & !mem_we;
        pop       = mem_rvalid & (cnt_q != '0);
        head      = id_q[rd_q];
        ic_rvalid = pop & !head;
        dc_rvalid = pop & head;
        ic_rdata  = mem_rdata;
        dc_rdata  = mem_rdata;
        last_d    = acc ? (sel_dc ? SRC_DC : SRC_IC) : last_q;
        wr_d      = push ? nxt(wr_q) : wr_q;
        rd_d      = pop ? nxt(rd_q) : rd_q;
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        err_d     = err_q | (mem_rvalid & !pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q <= SRC_IC;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) id_q[wr_q] <= sel_dc;
    end

    assign arb_err = err_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] pic_q, pdc_q, pst_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pic_q <= '0;
            pdc_q <= '0;
            pst_q <= '0;
        end else begin
            if (ic_gnt && pic_q != '1) pic_q <= pic_q + 32'd1;
            if (dc_gnt && pdc_q != '1) pdc_q <= pdc_q + 32'd1;
            if ((ic_req | dc_req) && !(ic_gnt | dc_gnt) && pst_q != '1) pst_q <= pst_q + 32'd1;
        end
    end

    assign perf_ic_grants    = pic_q;
    assign perf_dc_grants    = pdc_q;
    assign perf_stall_cycles = pst_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven grant checks plus scoreboarded read sequences against a
// 10-cycle pipelined memory model.
module tb_mem_arbiter;
    logic         clk, rstn;
    logic         ic_req, ic_we, ic_gnt, ic_rvalid, dc_req, dc_we, dc_gnt, dc_rvalid;
    logic [31:0]  ic_addr, dc_addr, mem_addr;
    logic [127:0] ic_wdata, dc_wdata, ic_rdata, dc_rdata, mem_wdata, mem_rdata;
    logic         mem_req, mem_we, mem_gnt, mem_rvalid, arb_err, force_rv;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]  perf_ic_grants, perf_dc_grants, perf_stall_cycles;
`endif

    mem_arbiter dut (
        .clk(clk), .rstn(rstn),
        .ic_req(ic_req), .ic_we(ic_we), .ic_addr(ic_addr), .ic_wdata(ic_wdata),
        .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .arb_err(arb_err)
`ifdef MEM_ARB_PERF_EN
        , .perf_ic_grants(perf_ic_grants), .perf_dc_grants(perf_dc_grants),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    typedef struct {bit who; logic [127:0] data; int due;} exp_t;
    typedef struct {bit who; int cyc;} glog_t;
    typedef struct {logic icr, icw, dcr, dcw, g, eic, edc; int sel;} vec_t;

    exp_t         sb[$];
    glog_t        glog[$];
    vec_t         tv[11];
    int           total = 0, bad = 0, cyc = 0;
    int           gs[11];
    logic [127:0] mem_a [256];
    logic         pv [10];
    logic [127:0] pd [10];

    function automatic logic [127:0] line_of(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'd1};
    endfunction

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cyc %0d)", n, a, e, cyc);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Memory model: always-accepting unless mem_gnt is pulled low, 10-cycle read latency.
    initial for (int i = 0; i < 256; i++) mem_a[i] = line_of(32'(i) << 4);
    assign mem_rvalid = pv[9] | force_rv;
    assign mem_rdata  = pd[9];
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 10; i++) pv[i] <= 1'b0;
        end else begin
            for (int i = 9; i > 0; i--) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
            pv[0] <= mem_req & mem_gnt & !mem_we;
            pd[0] <= mem_a[mem_addr[11:4]];
            if (mem_req & mem_gnt & mem_we) mem_a[mem_addr[11:4]] <= mem_wdata;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rstn) begin
            chk("no_dual_rvalid", ic_rvalid & dc_rvalid, 0);
            if (ic_rvalid || dc_rvalid) begin
                chk("rvalid_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rv_who", dc_rvalid, e.who);
                    chk("rv_data", dc_rvalid ? dc_rdata : ic_rdata, e.data);
                    chk("rv_cycle", cyc, e.due);
                end
            end
        end
    end

    task automatic idle(input bit who);
        if (who) dc_req = 1'b0; else ic_req = 1'b0;
    endtask

    task automatic xfer(input bit who, input bit we, input logic [31:0] addr, input logic [127:0] wd,
                        input logic [127:0] exp, input int budget, output int gcyc);
        if (who) begin dc_req = 1; dc_we = we; dc_addr = addr; dc_wdata = wd; end
        else     begin ic_req = 1; ic_we = we; ic_addr = addr; ic_wdata = wd; end
        gcyc = -1;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (who ? dc_gnt : ic_gnt) begin
                gcyc = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("gnt_in_budget", gcyc >= 0, 1);
        if (gcyc >= 0) begin
            glog.push_back('{who, gcyc});
            if (!we) sb.push_back('{who, exp, gcyc + 10});
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 0; ic_req = 0; dc_req = 0;
        sb.delete();
        repeat (2) @(negedge clk);
        rstn = 1;
        @(negedge clk);
    endtask

    initial begin : timeout
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int g, c, gl;
        rstn = 0; mem_gnt = 1; force_rv = 0;
        ic_req = 0; ic_we = 0; ic_addr = 0; ic_wdata = 0;
        dc_req = 0; dc_we = 0; dc_addr = 0; dc_wdata = 0;
        // {ic_req, ic_we, dc_req, dc_we, mem_gnt, exp ic_gnt, exp dc_gnt, selected 0/1=IC/2=DC}
        tv[0]  = '{0, 0, 0, 0, 1, 0, 0, 0};
        tv[1]  = '{1, 1, 1, 1, 1, 0, 1, 2};
        tv[2]  = '{1, 1, 1, 1, 1, 1, 0, 1};
        tv[3]  = '{1, 1, 1, 1, 0, 0, 0, 2};
        tv[4]  = '{1, 1, 1, 1, 1, 0, 1, 2};
        tv[5]  = '{1, 1, 0, 0, 1, 1, 0, 1};
        tv[6]  = '{1, 1, 0, 0, 1, 1, 0, 1};
        tv[7]  = '{0, 0, 1, 1, 1, 0, 1, 2};
        tv[8]  = '{1, 1, 1, 1, 0, 0, 0, 1};
        tv[9]  = '{1, 1, 1, 1, 1, 1, 0, 1};
        tv[10] = '{1, 1, 1, 1, 1, 0, 1, 2};

        repeat (3) @(negedge clk);
        chk("rst_ic_gnt", ic_gnt, 0);
        chk("rst_dc_gnt", dc_gnt, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_ic_rvalid", ic_rvalid, 0);
        chk("rst_dc_rvalid", dc_rvalid, 0);
        chk("rst_arb_err", arb_err, 0);
        rstn = 1;
        @(negedge clk);

        for (int r = 0; r < 11; r++) begin
            ic_req = tv[r].icr; ic_we = tv[r].icw; ic_addr = 32'h300 + 32'(r) * 16; ic_wdata = {4{ic_addr}};
            dc_req = tv[r].dcr; dc_we = tv[r].dcw; dc_addr = 32'h600 + 32'(r) * 16; dc_wdata = {4{~dc_addr}};
            mem_gnt = tv[r].g;
            #1;
            chk($sformatf("tv%0d_ic_gnt", r), ic_gnt, tv[r].eic);
            chk($sformatf("tv%0d_dc_gnt", r), dc_gnt, tv[r].edc);
            chk($sformatf("tv%0d_mem_req", r), mem_req, tv[r].sel != 0);
            if (tv[r].sel != 0) begin
                chk($sformatf("tv%0d_mem_we", r), mem_we, 1);
                chk($sformatf("tv%0d_mem_addr", r), mem_addr, tv[r].sel == 2 ? dc_addr : ic_addr);
                chk($sformatf("tv%0d_mem_wdata", r), mem_wdata, tv[r].sel == 2 ? dc_wdata : ic_wdata);
            end
            @(negedge clk);
        end
        ic_req = 0; dc_req = 0; mem_gnt = 1;
        do_reset();

        // single IC read, granted the cycle it is raised
        c = cyc;
        xfer(0, 0, 32'h100, '0, line_of(32'h100), 30, g);
        idle(0);
        chk("t1_gnt_cycle", g, c);
        drain();

        // both hold reads from reset: D,I,D,I
        do_reset();
        glog.delete();
        fork
            begin int a; xfer(0, 0, 32'h110, '0, line_of(32'h110), 30, a); xfer(0, 0, 32'h120, '0, line_of(32'h120), 30, a); idle(0); end
            begin int b; xfer(1, 0, 32'h130, '0, line_of(32'h130), 30, b); xfer(1, 0, 32'h140, '0, line_of(32'h140), 30, b); idle(1); end
        join
        chk("t2_glen", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) begin
            chk($sformatf("t2_who%0d", i), glog[i].who, (i % 2) == 0);
            chk($sformatf("t2_cyc%0d", i), glog[i].cyc - glog[0].cyc, i);
        end
        drain();

        // IC read at t, DC read at t+1
        glog.delete();
        fork
            begin int a; xfer(0, 0, 32'h150, '0, line_of(32'h150), 30, a); idle(0); end
            begin int b; @(negedge clk); xfer(1, 0, 32'h160, '0, line_of(32'h160), 30, b); idle(1); end
        join
        chk("t5_glen", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("t5_first_ic", glog[0].who, 0);
            chk("t5_dc_next", glog[1].cyc - glog[0].cyc, 1);
        end
        drain();

        // eleven DC reads: the eleventh waits until the cycle after the first response
        for (int i = 0; i < 11; i++) xfer(1, 0, 32'h800 + 32'(i) * 16, '0, line_of(32'h800 + 32'(i) * 16), 30, gs[i]);
        idle(1);
        chk("t3_b2b", gs[9] - gs[0], 9);
        chk("t3_held", gs[10] - gs[0], 11);
        drain();

        // FIFO full: a DC write still goes through at once
        for (int i = 0; i < 10; i++) xfer(0, 0, 32'hA00 + 32'(i) * 16, '0, line_of(32'hA00 + 32'(i) * 16), 30, gl);
        idle(0);
        xfer(1, 1, 32'h200, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE, '0, 1, g);
        idle(1);
        chk("t4_wr_when_full", g, gl + 1);
        drain();
        xfer(1, 0, 32'h200, '0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE, 30, g);
        idle(1);
        drain();

        // reset with a read in flight: FIFO flushed, later DC read routes to DC
        xfer(0, 0, 32'h170, '0, line_of(32'h170), 30, g);
        idle(0);
        repeat (4) @(negedge clk);
        do_reset();
        repeat (14) @(negedge clk);
        xfer(1, 0, 32'h180, '0, line_of(32'h180), 30, g);
        idle(1);
        drain();

        // stray response with empty FIFO
        chk("t6_err_pre", arb_err, 0);
        force_rv = 1;
        #1;
        chk("t6_no_ic_rvalid", ic_rvalid, 0);
        chk("t6_no_dc_rvalid", dc_rvalid, 0);
        @(negedge clk);
        force_rv = 0;
        chk("t6_err_set", arb_err, 1);
        repeat (3) @(negedge clk);
        chk("t6_err_sticky", arb_err, 1);
        do_reset();
        chk("t6_err_cleared", arb_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
